// File: rtl/dwt_engine_arbiter.sv
// Round-robin scheduler sharing one fp32 wavelet engine between NREQ level requesters.
// Define DWT_ARB_ERRCHK_EN to build the sticky err_unexp / err_miss result checks.
module dwt_engine_arbiter #(
  parameter int NREQ      = 3,
  parameter int ENG_LAT   = 14,
  parameter int ISSUE_GAP = 4
) (
  input  logic                clk_312_5,
  input  logic                rstn,
  input  logic [NREQ-1:0]     req_valid,
  input  logic [NREQ*256-1:0] req_data,
  output logic [NREQ-1:0]     req_ready,
  output logic                eng_valid,
  output logic [255:0]        eng_data,
  input  logic                eng_res_valid,
  input  logic [127:0]        eng_res_data,
  output logic [NREQ-1:0]     rsp_valid,
  output logic [127:0]        rsp_data,
  input  logic                flush,
  output logic                flush_done,
  output logic                busy,
  output logic                err_unexp,
  output logic                err_miss
);
  localparam int CW = $clog2(ENG_LAT / ISSUE_GAP + 2);
  localparam int GW = $clog2(ISSUE_GAP + 1);
  // GRANT->GAP and GAP->GRANT each take one edge, so GAP dwells ISSUE_GAP-2 extra cycles
  localparam logic [GW-1:0] GAP_LOAD = (ISSUE_GAP > 1) ? GW'(ISSUE_GAP - 2) : '0;

  typedef enum logic [2:0] {S_IDLE, S_GRANT, S_GAP, S_DRAIN, S_FLUSHED} state_t;

  state_t               state_q, state_d;
  logic [1:0]           last_q, gnt_q, gnt_d, win_idx, eng_tag, exp_tag;
  logic [2:0]           cand;
  logic [3:0]           vld_pad;
  logic                 win_any, hs, exp_vld, res_hit;
  logic [NREQ-1:0]      ready_d;
  logic [GW-1:0]        gap_q, gap_d;
  logic [CW-1:0]        inflight;
  logic [255:0]         iss_data;
  logic [ENG_LAT-1:0]   vld_pipe;
  logic [ENG_LAT-1:0][1:0] tag_pipe;

  assign vld_pad = 4'(req_valid);

  // search last+1, last+2, ... modulo NREQ
  always_comb begin
    win_idx = last_q;
    win_any = 1'b0;
    cand    = '0;
    for (int k = 1; k <= NREQ; k++) begin
      cand = {1'b0, last_q} + 3'(k);
      if (cand >= 3'(NREQ)) cand = cand - 3'(NREQ);
      if (!win_any && vld_pad[cand[1:0]]) begin
        win_any = 1'b1;
        win_idx = cand[1:0];
      end
    end
  end

  assign hs = (state_q == S_GRANT) && vld_pad[gnt_q];

  always_comb begin
    iss_data = '0;
    for (int r = 0; r < NREQ; r++)
      if (gnt_q == 2'(r)) iss_data = req_data[256*r +: 256];
  end

  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    gap_d   = gap_q;
    ready_d = '0;
    case (state_q)
      S_IDLE: begin
        if (flush) state_d = S_DRAIN;
        else if (win_any) begin
          state_d = S_GRANT;
          gnt_d   = win_idx;
          ready_d = NREQ'(4'b0001 << win_idx);
        end
      end
      S_GRANT: begin
        if (hs) gap_d = GAP_LOAD;
        if (flush)   state_d = S_DRAIN;
        else if (hs) state_d = S_GAP;
        else         state_d = S_IDLE;
      end
      S_GAP: begin
        if (flush) state_d = S_DRAIN;
        else if (gap_q != '0) gap_d = gap_q - GW'(1);
        else if (win_any) begin
          state_d = S_GRANT;
          gnt_d   = win_idx;
          ready_d = NREQ'(4'b0001 << win_idx);
        end else state_d = S_IDLE;
      end
      S_DRAIN:   if (inflight == '0) state_d = S_FLUSHED;
      S_FLUSHED: if (!flush) state_d = S_IDLE;
      default:   state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_312_5 or negedge rstn) begin
    if (!rstn) begin
      state_q   <= S_IDLE;
      req_ready <= '0;
      gnt_q     <= '0;
      gap_q     <= '0;
      last_q    <= 2'(NREQ - 1);
      eng_valid <= 1'b0;
      eng_data  <= '0;
      eng_tag   <= '0;
    end else begin
      state_q   <= state_d;
      req_ready <= ready_d;
      gnt_q     <= gnt_d;
      gap_q     <= gap_d;
      eng_valid <= hs;
      if (hs) begin
        last_q   <= gnt_q;
        eng_data <= iss_data;
        eng_tag  <= gnt_q;
      end
    end
  end

  // tag line is fed from the issue strobe so its tail lines up with eng_valid+ENG_LAT
  always_ff @(posedge clk_312_5 or negedge rstn) begin
    if (!rstn) begin
      vld_pipe <= '0;
      tag_pipe <= '0;
    end else begin
      vld_pipe <= {vld_pipe[ENG_LAT-2:0], eng_valid};
      tag_pipe <= {tag_pipe[ENG_LAT-2:0], eng_tag};
    end
  end

  assign exp_vld = vld_pipe[ENG_LAT-1];
  assign exp_tag = tag_pipe[ENG_LAT-1];
  assign res_hit = exp_vld && eng_res_valid;

  always_ff @(posedge clk_312_5 or negedge rstn) begin
    if (!rstn) inflight <= '0;
    else begin
      case ({hs, exp_vld})
        2'b10:   inflight <= inflight + CW'(1);
        2'b01:   inflight <= inflight - CW'(1);
        default: inflight <= inflight;
      endcase
    end
  end

  always_ff @(posedge clk_312_5 or negedge rstn) begin
    if (!rstn) begin
      rsp_valid <= '0;
      rsp_data  <= '0;
    end else begin
      rsp_valid <= res_hit ? NREQ'(4'b0001 << exp_tag) : '0;
      if (res_hit) rsp_data <= eng_res_data;
    end
  end

  assign busy       = (inflight != '0);
  assign flush_done = (state_q == S_FLUSHED);

`ifdef DWT_ARB_ERRCHK_EN
  logic err_unexp_q, err_miss_q;
  always_ff @(posedge clk_312_5 or negedge rstn) begin
    if (!rstn) begin
      err_unexp_q <= 1'b0;
      err_miss_q  <= 1'b0;
    end else begin
      if (eng_res_valid && !exp_vld) err_unexp_q <= 1'b1;
      if (exp_vld && !eng_res_valid) err_miss_q  <= 1'b1;
    end
  end
  assign err_unexp = err_unexp_q;
  assign err_miss  = err_miss_q;
`else
  assign err_unexp = 1'b0;
  assign err_miss  = 1'b0;
`endif

endmodule

// File: tb/tb_dwt_engine_arbiter.sv
// Directed bench for dwt_engine_arbiter: echo engine model plus cycle-exact response scoreboard.
module tb_dwt_engine_arbiter;
  localparam int NREQ = 3, ENG_LAT = 14, ISSUE_GAP = 4;
`ifdef DWT_ARB_ERRCHK_EN
  localparam bit ERRCHK = 1'b1;
`else
  localparam bit ERRCHK = 1'b0;
`endif

  logic clk = 1'b0;
  logic rstn;
  logic [NREQ-1:0] req_valid, req_ready, rsp_valid;
  logic [NREQ-1:0][255:0] rdata;
  logic [NREQ*256-1:0] req_data;
  logic eng_valid, eng_res_valid, flush, flush_done, busy, err_unexp, err_miss;
  logic [255:0] eng_data;
  logic [127:0] eng_res_data, rsp_data;
  logic spur = 1'b0, sup_req = 1'b0;

  assign req_data = rdata;

  dwt_engine_arbiter #(.NREQ(NREQ), .ENG_LAT(ENG_LAT), .ISSUE_GAP(ISSUE_GAP)) dut (
    .clk_312_5(clk), .rstn(rstn), .req_valid(req_valid), .req_data(req_data),
    .req_ready(req_ready), .eng_valid(eng_valid), .eng_data(eng_data),
    .eng_res_valid(eng_res_valid), .eng_res_data(eng_res_data),
    .rsp_valid(rsp_valid), .rsp_data(rsp_data), .flush(flush),
    .flush_done(flush_done), .busy(busy), .err_unexp(err_unexp), .err_miss(err_miss));

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // engine model: echoes eng_data[127:0] ENG_LAT cycles after eng_valid
  logic [ENG_LAT-1:0] e_v = '0, e_s = '0;
  logic [127:0] e_d [ENG_LAT];
  always @(posedge clk) begin
    e_v <= {e_v[ENG_LAT-2:0], eng_valid};
    e_s <= {e_s[ENG_LAT-2:0], sup_req};
    e_d[0] <= eng_data[127:0];
    for (int i = 1; i < ENG_LAT; i++) e_d[i] <= e_d[i-1];
  end
  assign eng_res_valid = (e_v[ENG_LAT-1] & ~e_s[ENG_LAT-1]) | spur;
  assign eng_res_data  = e_d[ENG_LAT-1];

  int n_assert = 0, n_fail = 0;
  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  typedef struct { int tag; logic [127:0] d; int due; bit sup; } exp_t;
  exp_t sb[$];
  int hs_cyc = -100, last_iss = -100;
  logic [255:0] hs_data = '0;

  always @(negedge clk) begin
    if (!rstn) begin
      hs_cyc = -100;
      last_iss = -100;
    end else begin
      chk("issue_strobe", eng_valid, cyc == hs_cyc + 1);
      if (eng_valid) begin
        chk("issue_data", eng_data, hs_data);
        if (last_iss >= 0) chk("issue_spacing", (cyc - last_iss) >= ISSUE_GAP, 1'b1);
        last_iss = cyc;
      end
      chk("ready_onehot0", $onehot0(req_ready), 1'b1);
      for (int r = 0; r < NREQ; r++)
        if (req_valid[r] && req_ready[r]) begin
          hs_cyc  = cyc;
          hs_data = rdata[r];
          sb.push_back('{r, rdata[r][127:0], cyc + 16, sup_req});
        end
      if (sb.size() != 0 && sb[0].due == cyc) begin
        exp_t e;
        e = sb.pop_front();
        if (e.sup) chk("rsp_suppressed", rsp_valid, 0);
        else begin
          chk("rsp_valid", rsp_valid, NREQ'(1) << e.tag);
          chk("rsp_data", rsp_data, e.d);
        end
      end else chk("rsp_quiet", rsp_valid, 0);
    end
  end

  int left [NREQ];
  int seq = 0;

  task automatic step();
    logic [NREQ-1:0] hs;
    hs = req_valid & req_ready;
    @(posedge clk); #1;
    for (int r = 0; r < NREQ; r++)
      if (hs[r]) begin
        left[r]--;
        seq++;
        rdata[r][31:0]   = {8'hA0 | 8'(r), 8'h00, 16'(seq)};
        rdata[r][127:32] = {$urandom, $urandom, $urandom};
        if (left[r] <= 0) req_valid[r] = 1'b0;
      end
  endtask

  task automatic wait_drain(input string tag);
    int w;
    w = 0;
    while (busy && w < 60) begin step(); w++; end
    step();
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_sb_empty"}, sb.size(), 0);
  endtask

  task automatic wait_sent();
    int w;
    w = 0;
    while (req_valid != '0 && w < 40) begin step(); w++; end
    chk("sent_all", req_valid, 0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int m, g, w, hs3;
    rstn = 1'b0; req_valid = '0; flush = 1'b0;
    for (int r = 0; r < NREQ; r++) begin
      rdata[r] = {8{$urandom}};
      left[r]  = 0;
    end
    repeat (3) @(posedge clk);
    #1;
    chk("rst_ready", req_ready, 0);
    chk("rst_eng_valid", eng_valid, 0);
    chk("rst_eng_data", eng_data, 0);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_rsp_data", rsp_data, 0);
    chk("rst_flush_done", flush_done, 0);
    chk("rst_busy", busy, 0);
    chk("rst_err_unexp", err_unexp, 0);
    chk("rst_err_miss", err_miss, 0);
    rstn = 1'b1;
    step(); step();

    // all three requesters held valid: 0,1,2,0,1,2 every ISSUE_GAP cycles
    for (int r = 0; r < NREQ; r++) left[r] = 2;
    m = cyc;
    req_valid = '1;
    for (int k = 0; k < 6; k++) begin
      w = 0;
      while (req_ready == '0 && w < 12) begin step(); w++; end
      chk("rr_grant", req_ready, NREQ'(1) << (k % 3));
      chk("rr_grant_cycle", cyc, m + 1 + 4 * k);
      step();
    end
    wait_drain("rr_drain");

    // requester 2 drops while granted
    left[2] = 1;
    req_valid[2] = 1'b1;
    step();
    chk("drop_grant", req_ready, 3'b100);
    req_valid[2] = 1'b0;
    left[2] = 0;
    step();
    chk("drop_ready_low", req_ready, 0);
    chk("drop_no_issue", eng_valid, 0);
    step();
    chk("drop_no_issue2", eng_valid, 0);
    chk("drop_not_busy", busy, 0);
    left[0] = 1; left[1] = 1;
    req_valid[0] = 1'b1; req_valid[1] = 1'b1;
    step();
    chk("after_drop_grant", req_ready, 3'b001);
    wait_sent();
    wait_drain("drop_drain");

    // single request on requester 1
    left[1] = 1;
    rdata[1][31:0] = 32'h3f800000;
    req_valid[1] = 1'b1;
    step();
    chk("single_ready", req_ready, 3'b010);
    step();
    chk("single_eng_valid", eng_valid, 1);
    chk("single_eng_w0", eng_data[31:0], 32'h3f800000);
    chk("single_busy", busy, 1);
    repeat (15) step();
    chk("single_rsp_valid", rsp_valid, 3'b010);
    chk("single_rsp_w0", rsp_data[31:0], 32'h3f800000);
    wait_drain("single_drain");

    // flush with nothing in flight
    flush = 1'b1;
    step();
    chk("flush0_d1", flush_done, 0);
    step();
    chk("flush0_d2", flush_done, 1);
    flush = 1'b0;
    step();
    chk("flush0_release", flush_done, 0);

    // flush raised on the third grant: that handshake completes, then drain
    for (int r = 0; r < NREQ; r++) left[r] = 2;
    req_valid = '1;
    g = 0; w = 0;
    while (w < 30) begin
      if (req_ready != '0) g++;
      if (g == 3) break;
      step();
      w++;
    end
    chk("flush_third_grant", g, 3);
    flush = 1'b1;
    step();
    hs3 = cyc - 1;
    chk("flush_ready_low", req_ready, 0);
    chk("flush_last_issue", eng_valid, 1);
    chk("flush_busy", busy, 1);
    w = 0;
    while (!flush_done && w < 40) begin
      chk("flush_no_ready", req_ready, 0);
      step();
      w++;
    end
    chk("flush_done_cycle", cyc, hs3 + 17);
    chk("flush_done_sb_empty", sb.size(), 0);
    chk("flush_done_idle", busy, 0);
    req_valid = '0;
    for (int r = 0; r < NREQ; r++) left[r] = 0;
    flush = 1'b0;
    step();
    chk("flush_release", flush_done, 0);

    // spurious result, then one suppressed result
    spur = 1'b1;
    step();
    spur = 1'b0;
    chk("spur_no_rsp", rsp_valid, 0);
    chk("spur_err_unexp", err_unexp, ERRCHK);
    chk("spur_err_miss_clear", err_miss, 0);
    sup_req = 1'b1;
    left[0] = 1;
    req_valid[0] = 1'b1;
    step(); step(); step();
    sup_req = 1'b0;
    wait_drain("sup_drain");
    chk("sup_err_miss", err_miss, ERRCHK);
    chk("sticky_err_unexp", err_unexp, ERRCHK);
    repeat (5) step();
    chk("sticky_err_miss", err_miss, ERRCHK);

    // reset with two blocks in flight
    left[0] = 1; left[1] = 1;
    req_valid[0] = 1'b1; req_valid[1] = 1'b1;
    wait_sent();
    chk("pre_rst_busy", busy, 1);
    chk("pre_rst_issue", eng_valid, 1);
    #2;
    rstn = 1'b0;
    sb.delete();
    #1;
    chk("arst_ready", req_ready, 0);
    chk("arst_eng_valid", eng_valid, 0);
    chk("arst_eng_data", eng_data, 0);
    chk("arst_rsp_valid", rsp_valid, 0);
    chk("arst_busy", busy, 0);
    chk("arst_flush_done", flush_done, 0);
    chk("arst_err_unexp", err_unexp, 0);
    chk("arst_err_miss", err_miss, 0);
    @(posedge clk); @(posedge clk); #1;
    rstn = 1'b1;
    for (int r = 0; r < NREQ; r++) left[r] = 1;
    req_valid = '1;
    step();
    chk("post_rst_grant", req_ready, 3'b001);
    wait_sent();
    wait_drain("post_rst_drain");

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
